// File: rtl/out_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : out_port_arbiter
// Description : Three-input round-robin output-port arbiter with destination
//               filtering, bounded bursts and a registered output flit stage.
// Revision    : 1.0 - initial release
// ============================================================================

module out_port_arbiter #(
    parameter int DataWidth = 32,
    parameter int DestMin   = 0,
    parameter int DestMax   = 0,
    parameter int MaxBurst  = 4
) (
    input  logic                 i_mclk,
    input  logic                 i_reset_n,
    input  logic [DataWidth-1:0] i_data1,
    input  logic [DataWidth-1:0] i_data2,
    input  logic [DataWidth-1:0] i_data3,
    input  logic                 i_data_valid1,
    input  logic                 i_data_valid2,
    input  logic                 i_data_valid3,
    output logic                 o_data_ready1,
    output logic                 o_data_ready2,
    output logic                 o_data_ready3,
    output logic [DataWidth-1:0] o_data,
    output logic                 o_data_valid,
    input  logic                 i_data_ready,
    output logic [1:0]           o_grant_src
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam logic [3:0]  C_BURST_LAST = 4'(MaxBurst - 1);
    localparam logic [31:0] C_DEST_MIN   = 32'(DestMin);
    localparam logic [31:0] C_DEST_MAX   = 32'(DestMax);

    state_t               state_q, state_d;
    logic [1:0]           last_q, last_d;
    logic [1:0]           grant_q, grant_d;
    logic [1:0]           grant_src_q, grant_src_d;
    logic [3:0]           burst_cnt_q, burst_cnt_d;
    logic [DataWidth-1:0] data_q, data_d;
    logic                 data_valid_q, data_valid_d;

    // Requester vectors are indexed by requester ID; slot 0 means "no grant".
    logic [DataWidth-1:0] w_data [4];
    logic [3:0]           w_valid;
    logic [3:0]           w_match;
    logic [3:0]           w_ready;
    logic                 w_load;
    logic                 w_transfer;
    logic [1:0]           w_cand1, w_cand2, w_cand3, w_sel;

    function automatic logic [1:0] next_id(input logic [1:0] id);
        return (id == 2'd3) ? 2'd1 : id + 2'd1;
    endfunction

    always_comb begin
        w_data[0] = '0;
        w_data[1] = i_data1;
        w_data[2] = i_data2;
        w_data[3] = i_data3;
        w_valid   = {i_data_valid3, i_data_valid2, i_data_valid1, 1'b0};
        w_load    = !data_valid_q || i_data_ready;
        w_match   = '0;
        w_ready   = '0;
        for (int k = 1; k < 4; k++) begin
            w_match[k] = w_valid[k]
                      && ({24'd0, w_data[k][DataWidth-1 -: 8]} >= C_DEST_MIN)
                      && ({24'd0, w_data[k][DataWidth-1 -: 8]} <= C_DEST_MAX);
            w_ready[k] = (state_q == ST_GRANT) && (grant_q == 2'(k))
                      && w_match[k] && w_load;
        end
        w_transfer = |w_ready;
    end

    // Search order starts just after the last owner so grants rotate.
    always_comb begin
        w_cand1 = next_id(last_q);
        w_cand2 = next_id(w_cand1);
        w_cand3 = next_id(w_cand2);
        w_sel   = 2'd0;
        if (w_match[w_cand1])      w_sel = w_cand1;
        else if (w_match[w_cand2]) w_sel = w_cand2;
        else if (w_match[w_cand3]) w_sel = w_cand3;
    end

    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        grant_d      = grant_q;
        grant_src_d  = grant_src_q;
        burst_cnt_d  = burst_cnt_q;
        data_d       = data_q;
        data_valid_d = data_valid_q;

        if (w_load) begin
            if (w_transfer) begin
                data_d       = w_data[grant_q];
                data_valid_d = 1'b1;
            end else begin
                data_valid_d = 1'b0;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (|w_match) begin
                    state_d     = ST_GRANT;
                    grant_d     = w_sel;
                    grant_src_d = w_sel;
                    burst_cnt_d = 4'd0;
                end
            end
            ST_GRANT: begin
                // A stalled output freezes the grant; otherwise a loaded cycle
                // without a transfer means the owner stopped matching.
                if (w_load) begin
                    if (w_transfer && (burst_cnt_q != C_BURST_LAST)) begin
                        burst_cnt_d = burst_cnt_q + 4'd1;
                    end else begin
                        state_d     = ST_IDLE;
                        last_d      = grant_q;
                        grant_d     = 2'd0;
                        grant_src_d = 2'd0;
                        burst_cnt_d = 4'd0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_mclk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            last_q       <= 2'd3;
            grant_q      <= 2'd0;
            grant_src_q  <= 2'd0;
            burst_cnt_q  <= 4'd0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            grant_q      <= grant_d;
            grant_src_q  <= grant_src_d;
            burst_cnt_q  <= burst_cnt_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
        end
    end

    assign o_data_ready1 = w_ready[1];
    assign o_data_ready2 = w_ready[2];
    assign o_data_ready3 = w_ready[3];
    assign o_data        = data_q;
    assign o_data_valid  = data_valid_q;
    assign o_grant_src   = grant_src_q;

endmodule

`default_nettype wire
